// File: rtl/jk_bank_driver.sv
// jk_bank_driver
//
// Command initiator for a bank of N JK flip-flops that share CLK with this
// block. A LOAD/SET/CLEAR/TOGGLE command is accepted over a REQ/ACK
// handshake in IDLE. The block then drives J/K excitation for one cycle
// (DRIVE) and checks the bank's Q against the latched target (CHECK). It
// reports DONE on a match. On a mismatch it retries up to RETRY times and
// then reports ERR.
//
// Parameters:
//   N      bank width (1..32)
//   RETRY  extra drive attempts after a failed check (0..7)
//
// Ports:
//   CLK    clock; all state updates on posedge
//   RSTB   asynchronous active-low reset
//   REQ    command request, only sampled in IDLE
//   CMD    00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE
//   DATA   LOAD value, or bit mask for SET/CLEAR/TOGGLE
//   Q      feedback from the JK bank outputs
//   J, K   registered excitation to the bank
//   ACK    one-cycle pulse, command accepted
//   BUSY   high while in DRIVE or CHECK
//   DONE   one-cycle pulse, bank reached the target
//   ERR    one-cycle pulse, retries exhausted without reaching the target

module jk_bank_driver #(
  parameter int N     = 8,
  parameter int RETRY = 2
) (
  input  logic         CLK,
  input  logic         RSTB,
  input  logic         REQ,
  input  logic [1:0]   CMD,
  input  logic [N-1:0] DATA,
  input  logic [N-1:0] Q,
  output logic [N-1:0] J,
  output logic [N-1:0] K,
  output logic         ACK,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] CMD_LOAD   = 2'b00;
  localparam logic [1:0] CMD_SET    = 2'b01;
  localparam logic [1:0] CMD_CLEAR  = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  localparam logic [2:0] RETRY_MAX = 3'(RETRY);

  state_t       state;
  logic [N-1:0] tgt;
  logic [2:0]   retry_cnt;

  logic [N-1:0] req_tgt;
  logic [N-1:0] req_diff;
  logic [N-1:0] chk_diff;

  // Target the bank should reach, derived from the Q seen at the accepting edge.
  always_comb begin
    req_tgt = DATA;
    case (CMD)
      CMD_LOAD:   req_tgt = DATA;
      CMD_SET:    req_tgt = Q | DATA;
      CMD_CLEAR:  req_tgt = Q & ~DATA;
      CMD_TOGGLE: req_tgt = Q ^ DATA;
      default:    req_tgt = DATA;
    endcase
  end

  // Bits that still have to move. Only these get set/reset excitation, so
  // J and K are never both high on a set/reset drive.
  assign req_diff = req_tgt ^ Q;
  assign chk_diff = tgt ^ Q;

  // Single FSM with all outputs registered. ACK/DONE/ERR default low each
  // cycle so they come out as one-cycle pulses. A TOGGLE uses J=K=mask only
  // on its first attempt; any retry falls back to set/reset excitation
  // computed from the current Q versus the latched target.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state     <= IDLE;
      tgt       <= '0;
      retry_cnt <= '0;
      J         <= '0;
      K         <= '0;
      ACK       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      ACK  <= 1'b0;
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          J <= '0;
          K <= '0;
          if (REQ) begin
            tgt   <= req_tgt;
            ACK   <= 1'b1;
            BUSY  <= 1'b1;
            state <= DRIVE;
            if (CMD == CMD_TOGGLE) begin
              J <= DATA;
              K <= DATA;
            end else begin
              J <= req_tgt & req_diff;
              K <= ~req_tgt & req_diff;
            end
          end
        end
        DRIVE: begin
          // The bank captures J/K on this edge; release it to hold afterwards.
          J     <= '0;
          K     <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (Q == tgt) begin
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            retry_cnt <= '0;
            state     <= IDLE;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + 3'd1;
            J         <= tgt & chk_diff;
            K         <= ~tgt & chk_diff;
            state     <= DRIVE;
          end else begin
            BUSY      <= 1'b0;
            ERR       <= 1'b1;
            retry_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          J     <= '0;
          K     <= '0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Initiator for a bank of N JK flip-flops: accepts a load/set/clear/toggle command over a REQ/ACK handshake and derives per-bit J/K excitation from the bank's current Q. It drives the excitation for one cycle, then reads back Q and reports DONE or, after bounded retries, ERR. It sits between control logic and any register built from JK flip-flops clocked on the same CLK.

## Interface
- N, default 8: bank width (1..32)
- RETRY, default 2: extra drive attempts after a failed check (0..7)

- CLK  input  1  clock; all state updates on posedge; the JK bank shares this clock
- RSTB  input  1  reset, asynchronous, active-low
- REQ  input  1  command request, sampled only in IDLE
- CMD  input  2  00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE
- DATA  input  N  LOAD value, or bit mask for SET/CLEAR/TOGGLE
- Q  input  N  feedback from the JK bank outputs
- J  output  N  J excitation, registered
- K  output  N  K excitation, registered
- ACK  output  1  one-cycle pulse: command accepted
- BUSY  output  1  high in DRIVE and CHECK
- DONE  output  1  one-cycle pulse: Q matched target
- ERR  output  1  one-cycle pulse: retries exhausted

## Operation
- States: IDLE, DRIVE, CHECK.
- Reset values: J=K=0, ACK=BUSY=DONE=ERR=0, retry count 0, state IDLE. RSTB low forces these immediately, in any state. The bank then holds (J=K=0). An aborted command produces no DONE or ERR.
- IDLE with REQ=1 at a posedge does the following:
  - Latch the target TGT: LOAD → DATA; SET → Q|DATA; CLEAR → Q&~DATA; TOGGLE → Q^DATA.
  - Compute excitation from the Q sampled at that edge.
  - Go to DRIVE; ACK=1 for that cycle.
- Excitation rules:
  - TOGGLE, first attempt: J=K=DATA.
  - All other cases: for bits where TGT≠Q, J=TGT and K=~TGT; elsewhere J=K=0.
  - Never drive J=K=1 except on the first TOGGLE attempt.
- DRIVE lasts one cycle; the bank captures J/K at the posedge ending DRIVE. Then go to CHECK with J=K=0.
- CHECK lasts one cycle and compares Q to TGT:
  - Equal: go to IDLE; DONE=1 in the next cycle.
  - Unequal and retry count < RETRY: increment the count, recompute set/reset excitation from current Q vs TGT, go to DRIVE.
  - Unequal and count = RETRY: go to IDLE; ERR=1 in the next cycle.
  - Leaving CHECK for IDLE clears the retry count.
- Null command (mask 0, or LOAD DATA equal to Q): the full DRIVE/CHECK sequence still runs with J=K=0, ending in DONE.
- REQ outside IDLE is ignored, not queued. CMD/DATA are only sampled in IDLE.

## Timing
- REQ sampled at the edge ending cycle n: ACK, BUSY, J/K valid in n+1; CHECK in n+2; DONE in n+3.
- Each retry adds 2 cycles. Worst-case ERR at n+3+2·RETRY.
- The cycle with DONE or ERR is IDLE, so a REQ in that cycle is accepted. Back-to-back commands issue every 3 cycles.
- DONE and ERR are mutually exclusive. ACK is never coincident with DONE or ERR.

## Test plan
- **Reset:** RSTB=0 with random REQ/DATA → J=K=0x00, ACK/BUSY/DONE/ERR=0; after release, state is IDLE and holds.
- **LOAD:** behavioural JK bank with Q=0x00, LOAD 0xA5 at n → n+1: ACK=1, J=0xA5, K=0x00; n+2: Q=0xA5, J=K=0; n+3: DONE=1.
- **TOGGLE then SET/CLEAR:**
  - Q=0xA5, TOGGLE 0x0F → J=K=0x0F, Q=0xAA, DONE.
  - Then SET 0x01 → J=0x01, K=0x00, Q=0xAB.
  - Then CLEAR 0x80 issued in the DONE cycle → accepted immediately; J=0x00, K=0x80, Q=0x2B.
- **Null command:** Q=0x3C, LOAD 0x3C → J=K=0 in DRIVE, DONE at n+3.
- **Retry/ERR:** bank bit0 stuck at 0, RETRY=2, LOAD 0x01 → DRIVE at n+1, n+3, n+5 each with J=0x01, K=0x00; ERR=1 at n+7; no DONE.
- **Abort and busy:** RSTB low during DRIVE → J/K=0 asynchronously, no DONE/ERR. REQ held high through BUSY → only one ACK per IDLE acceptance.
